// File: rtl/sram_rd_arbiter_if.sv
// Requester and SRAM bus bundle for the SRAM read arbiter.
// Valid/ready: a beat on requester i transfers in the cycle where req_valid[i] and req_ready[i] are
// both high. req_ready is combinational and never asserted without req_valid. Responses have no backpressure.
interface sram_rd_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      sram_rd_en;
    logic [ADDR_W-1:0]         sram_raddr;
    logic [DATA_W-1:0]         sram_rdata;

    modport slave (
        input  req_valid, req_addr, req_lock, sram_rdata,
        output req_ready, rsp_valid, rsp_data, sram_rd_en, sram_raddr
    );

    modport master (
        output req_valid, req_addr, req_lock, sram_rdata,
        input  req_ready, rsp_valid, rsp_data, sram_rd_en, sram_raddr
    );
endinterface

// File: rtl/sram_rd_arbiter.sv
// Multi-requester read arbiter for a synchronous SRAM: round-robin or fixed priority,
// burst lock with idle timeout, fixed 2-cycle in-order response pipeline.
module sram_rd_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 13,
    parameter int DATA_W  = 32,
    parameter int LOCK_TO = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                prio_mode,
    sram_rd_arbiter_if.slave    bus,
    output logic [1:0]          grant_id,
    output logic                busy,
    output logic                dbg_state
);
    localparam int CNT_W = $clog2(LOCK_TO) + 1;

    typedef enum logic {ARB = 1'b0, LOCK = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic [1:0]         owner_q, owner_d;
    logic [1:0]         grant_id_q, grant_id_d;
    logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic               rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]  raddr_q, raddr_d;
    logic [1:0]         id1_q, id1_d;
    logic               v2_q, v2_d;
    logic [1:0]         id2_q, id2_d;

    logic               found;
    logic [1:0]         win;
    logic [1:0]         idx;
    logic [NUM_REQ-1:0] ready;

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (int'(i) == NUM_REQ - 1) ? 2'd0 : i + 2'd1;
    endfunction

    // Winner search: locked owner only, else lowest index or first valid at/after rr_ptr.
    always_comb begin
        found = 1'b0;
        win   = 2'd0;
        idx   = 2'd0;
        if (state_q == LOCK) begin
            found = bus.req_valid[owner_q];
            win   = owner_q;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = prio_mode ? 2'(k) : 2'((int'(rr_ptr_q) + k) % NUM_REQ);
                if (!found && bus.req_valid[idx]) begin
                    found = 1'b1;
                    win   = idx;
                end
            end
        end
        ready = '0;
        if (found) ready[win] = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        grant_id_d = grant_id_q;
        idle_cnt_d = idle_cnt_q;
        rd_en_d    = found;
        raddr_d    = raddr_q;
        id1_d      = id1_q;
        v2_d       = rd_en_q;
        id2_d      = id1_q;
        if (found) begin
            raddr_d    = bus.req_addr[int'(win)*ADDR_W +: ADDR_W];
            id1_d      = win;
            grant_id_d = win;
            rr_ptr_d   = next_idx(win);
        end
        case (state_q)
            ARB: begin
                if (found && bus.req_lock[win]) begin
                    state_d    = LOCK;
                    owner_d    = win;
                    idle_cnt_d = '0;
                end
            end
            LOCK: begin
                if (found) begin
                    idle_cnt_d = '0;
                    if (!bus.req_lock[win]) state_d = ARB;
                end else if (idle_cnt_q == CNT_W'(LOCK_TO - 1)) begin
                    // Owner went quiet too long; free the bus and resume after it.
                    state_d    = ARB;
                    idle_cnt_d = '0;
                    rr_ptr_d   = next_idx(owner_q);
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB;
            rr_ptr_q   <= 2'd0;
            owner_q    <= 2'd0;
            grant_id_q <= 2'd0;
            idle_cnt_q <= '0;
            rd_en_q    <= 1'b0;
            raddr_q    <= '0;
            id1_q      <= 2'd0;
            v2_q       <= 1'b0;
            id2_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            grant_id_q <= grant_id_d;
            idle_cnt_q <= idle_cnt_d;
            rd_en_q    <= rd_en_d;
            raddr_q    <= raddr_d;
            id1_q      <= id1_d;
            v2_q       <= v2_d;
            id2_q      <= id2_d;
        end
    end

    always_comb begin
        bus.rsp_valid = '0;
        if (v2_q) bus.rsp_valid[id2_q] = 1'b1;
    end

    assign bus.req_ready  = ready;
    assign bus.rsp_data   = bus.sram_rdata;
    assign bus.sram_rd_en = rd_en_q;
    assign bus.sram_raddr = raddr_q;
    assign grant_id       = grant_id_q;
    assign busy           = rd_en_q | v2_q | (state_q == LOCK);
    assign dbg_state      = state_q;
endmodule

// File: doc/sram_rd_arbiter.md
SRAM_RD_ARBITER -- requirements
Module: sram_rd_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of read requesters (2..4).
REQ-002 Parameter ADDR_W, default 13: SRAM word address width.
REQ-003 Parameter DATA_W, default 32: SRAM data width.
REQ-004 Parameter LOCK_TO, default 16: idle cycles after which a held lock is force-released.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 prio_mode  in  1  0 = round-robin, 1 = fixed priority (index 0 highest).
REQ-008 req_valid  in  NUM_REQ  per-requester read request.
REQ-009 req_addr  in  NUM_REQ*ADDR_W  requester i address at [i*ADDR_W +: ADDR_W].
REQ-010 req_lock  in  NUM_REQ  keep grant after this beat (burst, e.g. 9-word weight preload).
REQ-011 req_ready  out  NUM_REQ  one-hot-or-zero grant; combinational from req_valid, state, pointer.
REQ-012 rsp_valid  out  NUM_REQ  one-hot-or-zero: read data for requester i on rsp_data this cycle.
REQ-013 rsp_data  out  DATA_W  equals sram_rdata.
REQ-014 sram_rd_en  out  1  active-high read enable to synchronous SRAM, registered.
REQ-015 sram_raddr  out  ADDR_W  registered read address.
REQ-016 sram_rdata  in  DATA_W  SRAM read data, valid the cycle after sram_rd_en=1.
REQ-017 grant_id  out  2  index of last accepted requester, registered.
REQ-018 busy  out  1  1 while any read is in flight (sram_rd_en or rsp pending) or state=LOCK.

Function
REQ-019 Handshake on requester i: req_valid[i] & req_ready[i] in cycle T; at most one per cycle; back-to-back handshakes every cycle allowed.
REQ-020 Accept at T -> sram_rd_en=1, sram_raddr=req_addr[i] in T+1 -> rsp_valid[i]=1, rsp_data=sram_rdata in T+2; fixed 2-cycle latency, no stall.
REQ-021 Responses return strictly in accept order; tag pipeline is 2 registered stages (id, valid).
REQ-022 No rsp backpressure: requester must consume rsp in its valid cycle.
REQ-023 Unaccepted requests carry no state; req_valid may drop before ready without effect.
REQ-024 States: ARB, LOCK; reset state ARB.
REQ-025 ARB, prio_mode=1: winner = lowest index with req_valid=1.
REQ-026 ARB, prio_mode=0: winner = first req_valid=1 searching from rr_ptr upward mod NUM_REQ; on accept rr_ptr <= (winner+1) mod NUM_REQ.
REQ-027 rr_ptr updates only on accept; it is retained (not cleared) when prio_mode changes; mode change applies in the same cycle.
REQ-028 ARB -> LOCK when accepted beat has req_lock[winner]=1; owner <= winner.
REQ-029 LOCK: only owner may receive req_ready; all others req_ready=0.
REQ-030 LOCK -> ARB when owner's accepted beat has req_lock=0; that beat is still issued; rr_ptr <= owner+1.
REQ-031 LOCK idle counter: increments each LOCK cycle with no owner handshake, clears on owner handshake; at count=LOCK_TO-1 next state ARB, counter cleared, rr_ptr <= owner+1.
REQ-032 Counter width clog2(LOCK_TO)+1; no wrap before release.
REQ-033 sram_rd_en=0 and sram_raddr holds previous value in cycles with no accept.
REQ-034 grant_id updates only on accept.

Reset
REQ-035 On rst_n=0, asynchronously: state=ARB, rr_ptr=0, owner=0, idle counter=0, tag pipeline cleared.
REQ-036 Reset outputs: req_ready per REQ-025/026 with rr_ptr=0 (0 when req_valid=0), rsp_valid=0, sram_rd_en=0, sram_raddr=0, grant_id=0, busy=0.
REQ-037 Reads in flight at reset are discarded; no rsp_valid after release for them.

Verification
REQ-038 prio_mode=0, req_valid=3'b111 held 6 cycles -> grants 0,1,2,0,1,2; rsp_valid one-hot 0,1,2,... two cycles after each.
REQ-039 prio_mode=1, req_valid=3'b110 -> req_ready=3'b010 every cycle; requester 2 never granted.
REQ-040 Req 0 issues 9 beats addr 7680..7688, req_lock=1 on first 8, req 1 valid throughout -> req 1 gets no ready until after beat 9; rsp_data order matches 7680..7688.
REQ-041 Req 2 locks then drops req_valid -> after LOCK_TO=16 idle cycles state=ARB, req 0 granted next cycle, busy falls.
REQ-042 rst_n low the cycle after an accept -> sram_rd_en=0, no rsp_valid on any port, rr_ptr=0 after release.
REQ-043 Single request addr 13'h1FFF with sram_rdata model = addr -> rsp_data=32'h1FFF exactly 2 cycles after handshake.
